// File: rtl/obj_code_mapper_pkg.sv
// obj_code_mapper_pkg: shared mode encoding and default geometry for the sprite code mapper
package obj_code_mapper_pkg;
  localparam int EXT_W_DEF      = 8;
  localparam int RAM_AW_DEF     = 12;
  localparam int CODE_IN_W_DEF  = 14;
  localparam int CODE_OUT_W_DEF = 20;
  localparam int NBANKS_DEF     = 8;
  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_SPRITE = 2'd1,
    MODE_BANK   = 2'd2,
    MODE_STICKY = 2'd3
  } mode_t;
endpackage

// File: rtl/dualport_ram_unreg.sv
// dualport_ram_unreg: extension RAM, read-only port A plus CPU read/write port B, read-before-write
module dualport_ram_unreg #(
  parameter int WIDTH   = 8,
  parameter int WIDTHAD = 12
) (
  input  logic               clk,
  input  logic [WIDTHAD-1:0] addr_a,
  output logic [WIDTH-1:0]   q_a,
  input  logic [WIDTHAD-1:0] addr_b,
  input  logic [WIDTH-1:0]   d_b,
  input  logic               we_b,
  output logic [WIDTH-1:0]   q_b
);
  logic [WIDTH-1:0] mem [2**WIDTHAD];
  // both ports read the pre-write contents, so a same-cycle write is seen only on the next access
  always_ff @(posedge clk) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= d_b;
  end
endmodule

// File: rtl/obj_code_mapper.sv
// obj_code_mapper: two-stage pipeline remapping sprite codes via extension RAM, bank registers or sticky groups
module obj_code_mapper
  import obj_code_mapper_pkg::*;
#(
  parameter int EXT_W      = EXT_W_DEF,
  parameter int RAM_AW     = RAM_AW_DEF,
  parameter int CODE_IN_W  = CODE_IN_W_DEF,
  parameter int CODE_OUT_W = CODE_OUT_W_DEF,
  parameter int NBANKS     = NBANKS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic                  frame_start,
  input  logic                  cs,
  input  logic                  bank_cs,
  input  logic [RAM_AW-1:0]     cpu_addr,
  input  logic [1:0]            cpu_ds_n,
  input  logic                  cpu_rw,
  input  logic [15:0]           din,
  output logic [15:0]           dout,
  input  logic                  code_req,
  input  logic [RAM_AW+2:0]     obj_addr,
  input  logic [CODE_IN_W-1:0]  code_original,
  output logic [CODE_OUT_W-1:0] code_modified,
  output logic                  code_valid
);
  localparam int BW = $clog2(NBANKS);
  logic                  we_ram, we_bank, v1, sel_bank, hold;
  mode_t                 m1;
  logic [CODE_IN_W-1:0]  c1;
  logic [EXT_W-1:0]      ext, cpu_q, bank_q, last_ext, last_eff, ext_sel;
  logic [EXT_W-1:0]      bank [NBANKS];
  logic [CODE_OUT_W-1:0] mapped;
  logic [7:0]            rd_byte;
  logic                  unused_bits;

  assign we_ram      = cs & ~cpu_rw & ~cpu_ds_n[0];
  assign we_bank     = bank_cs & ~cpu_rw & ~cpu_ds_n[0];
  assign rd_byte     = 8'(sel_bank ? bank_q : cpu_q);
  assign dout        = {rd_byte, rd_byte};
  assign unused_bits = ^{cpu_ds_n[1], obj_addr[2:0], din[15:EXT_W]};

  dualport_ram_unreg #(.WIDTH(EXT_W), .WIDTHAD(RAM_AW)) u_ram (
    .clk    (clk),
    .addr_a (obj_addr[RAM_AW+2:3]),
    .q_a    (ext),
    .addr_b (cpu_addr),
    .d_b    (din[EXT_W-1:0]),
    .we_b   (we_ram),
    .q_b    (cpu_q)
  );

  // CPU bank writes and the registered read-back path for dout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NBANKS; i++) bank[i] <= '0;
      bank_q   <= '0;
      sel_bank <= 1'b0;
    end else begin
      if (we_bank) bank[cpu_addr[BW-1:0]] <= din[EXT_W-1:0];
      bank_q   <= bank[cpu_addr[BW-1:0]];
      sel_bank <= bank_cs;
    end
  end

  // S1 mapping: a coincident frame_start wins over the remembered group so held entries map to 0
  always_comb begin
    hold     = ext[EXT_W-1];
    last_eff = frame_start ? '0 : last_ext;
    ext_sel  = hold ? last_eff : ext;
    mapped   = m1 == MODE_PASS   ? CODE_OUT_W'(c1) :
               m1 == MODE_SPRITE ? CODE_OUT_W'({ext, c1[7:0]}) :
               m1 == MODE_BANK   ? CODE_OUT_W'({bank[c1[CODE_IN_W-1 -: BW]], c1[CODE_IN_W-4:0]}) :
                                   CODE_OUT_W'({ext_sel[EXT_W-2:0], c1[7:0]});
  end

  // S0 capture, sticky-group memory and S2 output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1            <= 1'b0;
      m1            <= MODE_PASS;
      c1            <= '0;
      last_ext      <= '0;
      code_valid    <= 1'b0;
      code_modified <= '0;
    end else begin
      v1         <= code_req;
      m1         <= mode_t'(mode);
      c1         <= code_original;
      code_valid <= v1;
      if (v1) code_modified <= mapped;
      if (frame_start) last_ext <= '0;
      else if (v1 && m1 == MODE_STICKY && !hold) last_ext <= ext;
    end
  end
endmodule
